// File: rtl/uart_tx_report.sv
// Report encoder: snapshots the watch/stopwatch time and sends a 14-byte ASCII frame
// through the uart_tx start/busy/done handshake. Define AUTO_REPORT_EN for periodic reports.
module uart_tx_report #(
  parameter int PERIOD_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       w_rst,
  input  logic       send_req_i,
  input  logic       mode_i,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [6:0] csec_i,
  input  logic       tx_busy_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       report_busy_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2} state_e;
  localparam logic [3:0] LAST_IDX = 4'd13;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       mode_q;
  logic [4:0] hour_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic [6:0] csec_q;
  logic       snap_en_s;
  logic       req_s;
  logic       auto_req_s;
  logic [7:0] frame_byte_s;
  logic [7:0] hour_bcd_s, min_bcd_s, sec_bcd_s, csec_bcd_s;

  // Clamp to 99, then split into tens/ones by constant compares and one subtract.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = (v > 7'd99) ? 7'd99 : v;
    t = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if ((t == 4'd0) && (r >= 7'(10 * k))) begin
        t = 4'(k);
      end
    end
    r = r - (7'(t) * 7'd10);
    return {t, r[3:0]};
  endfunction

`ifdef AUTO_REPORT_EN
  localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  logic [CNT_W-1:0] period_cnt_q;

  assign auto_req_s = (period_cnt_q == CNT_W'(PERIOD_CYC - 1));

  // Free-running period counter; its wrap raises an internal request.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      period_cnt_q <= '0;
    end else if (auto_req_s) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_q + 1'b1;
    end
  end
`else
  logic unused_period_s;
  assign unused_period_s = ^PERIOD_CYC;
  assign auto_req_s      = 1'b0;
`endif

  assign req_s      = send_req_i | auto_req_s;
  assign hour_bcd_s = to_bcd({2'b00, hour_q});
  assign min_bcd_s  = to_bcd({1'b0, min_q});
  assign sec_bcd_s  = to_bcd({1'b0, sec_q});
  assign csec_bcd_s = to_bcd(csec_q);

  // Frame byte selected by the current index.
  always_comb begin
    frame_byte_s = 8'h00;
    case (idx_q)
      4'd0:    frame_byte_s = mode_q ? 8'h53 : 8'h57;
      4'd1:    frame_byte_s = {4'h3, hour_bcd_s[7:4]};
      4'd2:    frame_byte_s = {4'h3, hour_bcd_s[3:0]};
      4'd3:    frame_byte_s = 8'h3A;
      4'd4:    frame_byte_s = {4'h3, min_bcd_s[7:4]};
      4'd5:    frame_byte_s = {4'h3, min_bcd_s[3:0]};
      4'd6:    frame_byte_s = 8'h3A;
      4'd7:    frame_byte_s = {4'h3, sec_bcd_s[7:4]};
      4'd8:    frame_byte_s = {4'h3, sec_bcd_s[3:0]};
      4'd9:    frame_byte_s = 8'h2E;
      4'd10:   frame_byte_s = {4'h3, csec_bcd_s[7:4]};
      4'd11:   frame_byte_s = {4'h3, csec_bcd_s[3:0]};
      4'd12:   frame_byte_s = 8'h0D;
      4'd13:   frame_byte_s = 8'h0A;
      default: frame_byte_s = 8'h00;
    endcase
  end

  // Next-state logic; requests arriving mid-frame collapse into a single pending flag.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    snap_en_s  = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          snap_en_s = 1'b1;
          idx_d     = 4'd0;
          state_d   = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        pending_d = pending_q | req_s;
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte_s;
          state_d    = S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        pending_d = pending_q | req_s;
        if (!tx_done_i) begin
          state_d = S_WAIT;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SEND;
        end else if (pending_q | req_s) begin
          snap_en_s = 1'b1;
          idx_d     = 4'd0;
          pending_d = 1'b0;
          state_d   = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        idx_d     = 4'd0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      pending_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Time snapshot, frozen for the duration of a frame.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      mode_q <= 1'b0;
      hour_q <= 5'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      csec_q <= 7'd0;
    end else if (snap_en_s) begin
      mode_q <= mode_i;
      hour_q <= hour_i;
      min_q  <= min_i;
      sec_q  <= sec_i;
      csec_q <= csec_i;
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign report_busy_o = (state_q != S_IDLE);

endmodule
